byte_sr_ctrl: RTL and testbench

- Sequencing controller for the byte-wide shift register (byte_SR) in the systolic-array I/O path.
- Accepts whole SIZE-byte words over a valid/ready handshake and pulses the register's parallel load.
- Then presents one byte per downstream handshake, issuing shift enables and flagging the last byte of each word.
- Pure control: the datapath bytes come from the shift register's byte_out; this block only drives load/shift and the handshakes.

---
 rtl/byte_sr_pkg.sv | 11 +
 rtl/byte_sr_ctrl.sv | 99 +++++++++
 tb/tb_byte_sr_ctrl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/byte_sr_pkg.sv
// Shared types and constants for the byte shift-register controller.
package byte_sr_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int WORDS_DONE_W = 16;

endpackage

// File: rtl/byte_sr_ctrl.sv
// byte_sr_ctrl: load/shift sequencer and handshakes for a SIZE-byte shift register.
// Optional macro BYTE_SR_CTRL_B2B_EN: accept the next word on the last byte handshake.
module byte_sr_ctrl
  import byte_sr_pkg::*;
#(
  parameter  int SIZE  = 2,
  localparam int CNT_W = $clog2(SIZE) + 1
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    word_valid,
  output logic                    word_ready,
  output logic                    byte_valid,
  input  logic                    byte_ready,
  output logic                    byte_last,
  input  logic                    flush,
  output logic                    sr_load,
  output logic                    sr_shift,
  output logic                    busy,
  output logic [WORDS_DONE_W-1:0] words_done
);

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [WORDS_DONE_W-1:0] words_done_q, words_done_d;
  logic                    last_byte;

  assign last_byte  = (cnt_q == '0);
  assign words_done = words_done_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      words_done_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      words_done_q <= words_done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    words_done_d = words_done_q;
    word_ready   = 1'b0;
    byte_valid   = 1'b0;
    byte_last    = 1'b0;
    sr_load      = 1'b0;
    sr_shift     = 1'b0;
    busy         = 1'b0;

    case (state_q)
      IDLE: begin
        word_ready = 1'b1;
        if (word_valid) begin
          sr_load = 1'b1;
          cnt_d   = CNT_W'(SIZE - 1);
          state_d = SEND;
        end
      end
      SEND: begin
        byte_valid = 1'b1;
        busy       = 1'b1;
        byte_last  = last_byte;
        if (byte_ready) begin
          if (!last_byte) begin
            sr_shift = 1'b1;
            cnt_d    = cnt_q - CNT_W'(1);
          end else begin
            words_done_d = words_done_q + WORDS_DONE_W'(1);
            state_d      = IDLE;
`ifdef BYTE_SR_CTRL_B2B_EN
            word_ready = 1'b1;
            if (word_valid) begin
              sr_load = 1'b1;
              cnt_d   = CNT_W'(SIZE - 1);
              state_d = SEND;
            end
`endif
          end
        end
      end
      default: ;
    endcase

    // Abort overrides everything decided above; the register keeps stale data.
    if (flush) begin
      state_d      = IDLE;
      cnt_d        = '0;
      words_done_d = words_done_q;
      word_ready   = 1'b0;
      sr_load      = 1'b0;
      sr_shift     = 1'b0;
    end
  end

endmodule

// File: tb/tb_byte_sr_ctrl.sv
// Scoreboard bench for byte_sr_ctrl with a behavioural byte shift register attached.
module tb_byte_sr_ctrl;

  localparam int SIZE = 4;

  typedef struct packed {
    logic       last;
    logic [7:0] b;
  } exp_t;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic word_valid = 1'b0, byte_ready = 1'b0, flush = 1'b0;
  logic word_ready, byte_valid, byte_last, sr_load, sr_shift, busy;
  logic [15:0] words_done;
  logic [8*SIZE-1:0] parallel_in = '0;
  logic [8*SIZE-1:0] sr_q = '0;
  logic [7:0] byte_out;

  // second instance, one byte per word
  logic w1_valid = 1'b0;
  logic w1_ready, b1_valid, b1_last, l1, s1, busy1;
  logic [15:0] wd1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        q[$];
  exp_t        mon_e;
  logic [15:0] model_done = '0;

  always #5 clk = ~clk;

  byte_sr_ctrl #(.SIZE(SIZE)) dut (
    .clk(clk), .n_rst(n_rst), .word_valid(word_valid), .word_ready(word_ready),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .byte_last(byte_last),
    .flush(flush), .sr_load(sr_load), .sr_shift(sr_shift), .busy(busy),
    .words_done(words_done)
  );

  byte_sr_ctrl #(.SIZE(1)) dut1 (
    .clk(clk), .n_rst(n_rst), .word_valid(w1_valid), .word_ready(w1_ready),
    .byte_valid(b1_valid), .byte_ready(1'b1), .byte_last(b1_last),
    .flush(1'b0), .sr_load(l1), .sr_shift(s1), .busy(busy1),
    .words_done(wd1)
  );

  // Behavioural byte_SR: parallel load, shift toward the MSB byte, MSB byte out.
  always @(posedge clk) begin
    if (sr_load) sr_q <= parallel_in;
    else if (sr_shift) sr_q <= sr_q << 8;
  end
  assign byte_out = sr_q[8*SIZE-1 -: 8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor / scoreboard: expected bytes are queued on acceptance, popped on consumption.
  always @(negedge clk) begin
    if (!n_rst) begin
      q.delete();
      model_done = '0;
    end else begin
      check("words_done", words_done, model_done);
      check("load_shift_excl", sr_load & sr_shift, 0);
      check("busy_eq_valid", busy, byte_valid);
      if (!byte_valid) begin
        check("idle_last", byte_last, 0);
        check("idle_ready", word_ready, !flush);
      end else begin
`ifdef BYTE_SR_CTRL_B2B_EN
        check("send_ready", word_ready, byte_last & byte_ready & !flush);
`else
        check("send_ready", word_ready, 0);
`endif
      end
      check("load_rule", sr_load, word_valid & word_ready);
      check("shift_rule", sr_shift, byte_valid & byte_ready & !byte_last & !flush);
      if (flush) begin
        q.delete();
      end else begin
        if (byte_valid && byte_ready) begin
          if (q.size() == 0) begin
            check("unexpected_byte", 1, 0);
          end else begin
            mon_e = q.pop_front();
            check("byte_data", byte_out, mon_e.b);
            check("byte_last", byte_last, mon_e.last);
            if (mon_e.last) model_done = model_done + 16'd1;
          end
        end
        if (word_valid && word_ready) begin
          for (int i = 0; i < SIZE; i++)
            q.push_back('{last: (i == SIZE - 1), b: parallel_in[8*(SIZE-1-i) +: 8]});
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_word_ready"}, word_ready, 1);
    check({tag, "_byte_valid"}, byte_valid, 0);
    check({tag, "_byte_last"}, byte_last, 0);
    check({tag, "_sr_load"}, sr_load, 0);
    check({tag, "_sr_shift"}, sr_shift, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_words_done"}, words_done, 0);
  endtask

  initial begin
    logic [3:0]  tl_exp [6];
    logic [15:0] base;
    int          acc;
    logic        exp_v;
    logic        prev_ready, prev_valid;
    logic [7:0]  prev_byte;
    int          waited;

    tl_exp = '{4'b1000, 4'b0110, 4'b0110, 4'b0110, 4'b0101, 4'b0000};

    #3 check_reset_outputs("rst");
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");
    @(posedge clk); #1;

    // SIZE=1: three words, every byte last, never a shift
    w1_valid = 1'b1;
    acc = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      check("s1_no_shift", s1, 0);
      if (b1_valid) check("s1_last", b1_last, 1);
      if (w1_valid && w1_ready) acc++;
      @(posedge clk); #1;
      if (acc == 3) w1_valid = 1'b0;
    end
    @(negedge clk);
    check("s1_accepts", acc, 3);
    check("s1_words_done", wd1, 3);
    @(posedge clk); #1;

    // Single word, byte_ready held: exact load/valid/shift/last timeline
    base = model_done;
    word_valid = 1'b1; parallel_in = 32'hAABBCCDD; byte_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check($sformatf("t1_timeline_c%0d", c), {sr_load, byte_valid, sr_shift, byte_last}, tl_exp[c]);
      if (c == 5) check("t1_done", words_done, base + 16'd1);
      @(posedge clk); #1;
      word_valid = 1'b0;
    end

    // byte_ready toggling: output must hold on stall cycles
    base = model_done;
    word_valid = 1'b1; parallel_in = 32'hAABBCCDD; byte_ready = 1'b0;
    prev_ready = 1'b0; prev_valid = 1'b0; prev_byte = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (prev_valid && !prev_ready && byte_valid) check("t2_stall_hold", byte_out, prev_byte);
      prev_ready = byte_ready; prev_valid = byte_valid; prev_byte = byte_out;
      @(posedge clk); #1;
      word_valid = 1'b0;
      byte_ready = ((c + 1) % 2) == 1;
    end
    @(negedge clk);
    check("t2_idle", byte_valid, 0);
    check("t2_done", words_done, base + 16'd1);
    @(posedge clk); #1;

    // Two words with word_valid held high
    base = model_done;
    word_valid = 1'b1; parallel_in = 32'h11223344; byte_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 11; c++) begin
      @(negedge clk);
`ifdef BYTE_SR_CTRL_B2B_EN
      exp_v = (c >= 1 && c <= 8);
`else
      exp_v = (c >= 1 && c <= 4) || (c >= 6 && c <= 9);
`endif
      check($sformatf("t3_valid_c%0d", c), byte_valid, exp_v);
      if (word_valid && word_ready) acc++;
      @(posedge clk); #1;
      if (acc == 1) parallel_in = 32'h55667788;
      if (acc == 2) word_valid = 1'b0;
    end
    @(negedge clk);
    check("t3_accepts", acc, 2);
    check("t3_done", words_done, base + 16'd2);
    @(posedge clk); #1;

    // flush on the second byte, then a clean word
    base = model_done;
    word_valid = 1'b1; parallel_in = 32'hDEADBEEF; byte_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 3) begin
        check("t4_flushed_valid", byte_valid, 0);
        check("t4_flushed_done", words_done, base);
      end
      @(posedge clk); #1;
      word_valid = (c == 2);
      flush = (c == 1);
      if (c == 2) parallel_in = 32'h0BADF00D;
    end
    @(negedge clk);
    check("t4_next_word_done", words_done, base + 16'd1);
    @(posedge clk); #1;

    // Reset pulse mid-word (cnt=2)
    word_valid = 1'b1; parallel_in = 32'h01020304; byte_ready = 1'b1;
    @(posedge clk); #1 word_valid = 1'b0;
    @(posedge clk); #1 byte_ready = 1'b0;
    @(negedge clk);
    check("t5_in_flight", byte_valid, 1);
    #2 n_rst = 1'b0;
    #1 check_reset_outputs("t5_async");
    @(negedge clk);
    #2 n_rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("t5_release");
    @(posedge clk); #1;

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      word_valid  = ($urandom_range(0, 1) == 1);
      byte_ready  = ($urandom_range(0, 9) < 7);
      flush       = ($urandom_range(0, 31) == 0);
      parallel_in = $urandom;
      @(posedge clk); #1;
    end

    word_valid = 1'b0; flush = 1'b0; byte_ready = 1'b1;
    waited = 0;
    while ((q.size() != 0 || byte_valid) && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    check("drain_timeout", waited < 64, 1);
    check("drain_queue_empty", q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
